// File: rtl/mul_div_unit_if.sv
// rtl/mul_div_unit_if.sv - request/result bundle between control unit and mul_div_unit
interface mul_div_unit_if #(
   parameter int N = 32
);
   logic         start;
   logic [1:0]   op;
   logic [N-1:0] inA;
   logic [N-1:0] inB;
   logic         busy;
   logic         done;
   logic [N-1:0] hi;
   logic [N-1:0] lo;
   logic         div_by_zero;

   modport master (
      output start, op, inA, inB,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, inA, inB,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative radix-2 multiply / restoring divide unit with HI/LO results
module mul_div_unit #(
   parameter int N = 32
) (
   input logic           clock,
   input logic           reset,
   mul_div_unit_if.slave bus
);
   localparam int CW = $clog2(N) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;

   localparam logic [1:0] OP_MULT = 2'b01;
   localparam logic [1:0] OP_DIV  = 2'b11;

   logic [1:0]     state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [1:0]     op_q, op_d;
   logic           sign_a_q, sign_a_d;
   logic           sign_b_q, sign_b_d;
   logic           dbz_pend_q, dbz_pend_d;
   logic [N-1:0]   a_q, a_d;       // multiplicand, or dividend shifting out MSB-first
   logic [N-1:0]   b_q, b_d;       // multiplier shifting out LSB-first, or divisor
   logic [2*N-1:0] acc_q, acc_d;   // product, or {remainder, quotient}
   logic [N-1:0]   hi_q, hi_d;
   logic [N-1:0]   lo_q, lo_d;
   logic           done_q, done_d;
   logic           div_by_zero_q, div_by_zero_d;

   logic [N:0]     mul_sum;
   logic [N:0]     rem_sh;
   logic [N:0]     trial;
   logic [2*N-1:0] prod;
   logic [N-1:0]   quo;
   logic [N-1:0]   rem;

   // Next-state logic: operand capture, one iteration step, and sign-fixed result write-back
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      op_d          = op_q;
      sign_a_d      = sign_a_q;
      sign_b_d      = sign_b_q;
      dbz_pend_d    = dbz_pend_q;
      a_d           = a_q;
      b_d           = b_q;
      acc_d         = acc_q;
      hi_d          = hi_q;
      lo_d          = lo_q;
      done_d        = 1'b0;
      div_by_zero_d = div_by_zero_q;

      // Multiply step: conditional add into the upper half keeps its carry in bit N
      mul_sum = b_q[0] ? ({1'b0, acc_q[2*N-1:N]} + {1'b0, a_q}) : {1'b0, acc_q[2*N-1:N]};
      // Divide step: remainder after the shift can reach N+1 bits, so trial is N+1 wide
      rem_sh  = {acc_q[2*N-1:N], a_q[N-1]};
      trial   = rem_sh - {1'b0, b_q};

      // Magnitude results are sign-corrected only at write-back
      prod = acc_q;
      if (op_q == OP_MULT && (sign_a_q ^ sign_b_q)) prod = -acc_q;
      quo = acc_q[N-1:0];
      rem = acc_q[2*N-1:N];
      if (op_q == OP_DIV) begin
         if (sign_a_q ^ sign_b_q) quo = -acc_q[N-1:0];
         if (sign_a_q)            rem = -acc_q[2*N-1:N];
      end

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               op_d       = bus.op;
               sign_a_d   = bus.inA[N-1];
               sign_b_d   = bus.inB[N-1];
               acc_d      = '0;
               cnt_d      = CW'(N);
               a_d        = (bus.op[0] && bus.inA[N-1]) ? -bus.inA : bus.inA;
               b_d        = (bus.op[0] && bus.inB[N-1]) ? -bus.inB : bus.inB;
               dbz_pend_d = bus.op[1] && (bus.inB == '0);
               if (bus.op[1] && (bus.inB == '0)) begin
                  // Divide by zero returns the dividend untouched, so keep the raw value
                  a_d     = bus.inA;
                  state_d = S_FIN;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            cnt_d = cnt_q - CW'(1);
            if (!op_q[1]) begin
               acc_d = {mul_sum, acc_q[N-1:1]};
               b_d   = b_q >> 1;
            end else begin
               a_d = a_q << 1;
               if (!trial[N]) acc_d = {trial[N-1:0], acc_q[N-2:0], 1'b1};
               else           acc_d = {rem_sh[N-1:0], acc_q[N-2:0], 1'b0};
            end
            if (cnt_q == CW'(1)) state_d = S_FIN;
         end
         S_FIN: begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            if (dbz_pend_q) begin
               hi_d          = a_q;
               lo_d          = '1;
               div_by_zero_d = 1'b1;
            end else if (op_q[1]) begin
               hi_d          = rem;
               lo_d          = quo;
               div_by_zero_d = 1'b0;
            end else begin
               hi_d          = prod[2*N-1:N];
               lo_d          = prod[N-1:0];
               div_by_zero_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset discards any operation in flight
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         op_q          <= '0;
         sign_a_q      <= 1'b0;
         sign_b_q      <= 1'b0;
         dbz_pend_q    <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         acc_q         <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
         done_q        <= 1'b0;
         div_by_zero_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         op_q          <= op_d;
         sign_a_q      <= sign_a_d;
         sign_b_q      <= sign_b_d;
         dbz_pend_q    <= dbz_pend_d;
         a_q           <= a_d;
         b_q           <= b_d;
         acc_q         <= acc_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
         done_q        <= done_d;
         div_by_zero_q <= div_by_zero_d;
      end
   end

   assign bus.busy        = (state_q != S_IDLE);
   assign bus.done        = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = div_by_zero_q;
endmodule
